// File: rtl/display_scan_mux.sv
// Self-timed seven-segment digit scanner: prescaled digit select, one-hot enables,
// blank/blink masking, anti-ghosting dead time and a frame-start pulse.
module display_scan_mux #(
    parameter int unsigned     DIGITS       = 8,
    parameter int unsigned     DW           = 4,
    parameter int unsigned     PRESCALE     = 50000,
    parameter int unsigned     DEAD         = 2,
    parameter int unsigned     BLINK_FRAMES = 64,
    parameter logic [DW-1:0]   BLANK_CODE   = '1,
    localparam int unsigned    SELW         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIGITS*DW-1:0] din,
    input  logic [DIGITS-1:0]    blank_mask,
    input  logic [DIGITS-1:0]    blink_mask,
    output logic [SELW-1:0]      sel,
    output logic [DIGITS-1:0]    dig_en,
    output logic [DW-1:0]        q,
    output logic                 frame_start
);

    localparam int unsigned PW  = $clog2(PRESCALE);
    localparam int unsigned DCW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam int unsigned FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [DCW-1:0]    dead_q, dead_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              blink_q, blink_d;
    logic [DIGITS-1:0] dig_en_q, dig_en_d;
    logic [DW-1:0]     q_q, q_d;
    logic              frame_start_q, frame_start_d;

    logic              step;
    logic              wrap;
    logic              blanked;
    logic [DW-1:0]     digit [DIGITS];

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit[i] = din[i*DW +: DW];
        end
    end

    always_comb begin
        step    = en && (presc_q == PW'(PRESCALE - 1));
        wrap    = step && (sel_q == SELW'(DIGITS - 1));
        presc_d = presc_q;
        sel_d   = sel_q;
        dead_d  = dead_q;
        frame_d = frame_q;
        blink_d = blink_q;

        if (step) begin
            presc_d = '0;
            sel_d   = wrap ? '0 : sel_q + SELW'(1);
            dead_d  = DCW'(DEAD);
        end else if (en) begin
            presc_d = presc_q + PW'(1);
            if (dead_q != '0) begin
                dead_d = dead_q - DCW'(1);
            end
        end

        if (wrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end

        // Outputs follow next-state select/phase so they line up with sel_q.
        blanked       = blank_mask[sel_d] | (blink_mask[sel_d] & blink_d);
        dig_en_d      = (en && (dead_d == '0) && !blanked) ? (DIGITS'(1) << sel_d) : '0;
        q_d           = blanked ? BLANK_CODE : digit[sel_d];
        frame_start_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            sel_q         <= '0;
            dead_q        <= DCW'(DEAD);
            frame_q       <= '0;
            blink_q       <= 1'b0;
            dig_en_q      <= '0;
            q_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            sel_q         <= sel_d;
            dead_q        <= dead_d;
            frame_q       <= frame_d;
            blink_q       <= blink_d;
            dig_en_q      <= dig_en_d;
            q_q           <= q_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sel         = sel_q;
    assign dig_en      = dig_en_q;
    assign q           = q_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: two configurations checked against a closed-form
// model of enabled-cycle count, through a per-cycle expectation queue.
module tb_display_scan_mux;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    logic [15:0] din0;
    logic [3:0]  blank0, blink0;
    logic [1:0]  sel0;
    logic [3:0]  de0, q0;
    logic        fs0;

    logic [19:0] din1;
    logic [4:0]  blank1, blink1;
    logic [2:0]  sel1;
    logic [4:0]  de1;
    logic [3:0]  q1;
    logic        fs1;

    int errors = 0;
    int checks = 0;

    display_scan_mux #(
        .DIGITS(4), .DW(4), .PRESCALE(4), .DEAD(1), .BLINK_FRAMES(2), .BLANK_CODE(4'hF)
    ) u0 (
        .clk(clk), .rst(rst), .en(en), .din(din0),
        .blank_mask(blank0), .blink_mask(blink0),
        .sel(sel0), .dig_en(de0), .q(q0), .frame_start(fs0)
    );

    display_scan_mux #(
        .DIGITS(5), .DW(4), .PRESCALE(3), .DEAD(0), .BLINK_FRAMES(1), .BLANK_CODE(4'hF)
    ) u1 (
        .clk(clk), .rst(rst), .en(en), .din(din1),
        .blank_mask(blank1), .blink_mask(blink1),
        .sel(sel1), .dig_en(de1), .q(q1), .frame_start(fs1)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] de;
        logic [3:0] q;
        logic       fs;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   t0, t1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // t = enabled cycles since reset; everything follows from it arithmetically.
    function automatic exp_t calc(input int t, input int nd, input int p, input int dd,
                                  input int bf, input logic e, input logic [31:0] din,
                                  input logic [7:0] bm, input logic [7:0] km);
        exp_t r;
        int presc, slot, s, frame, ph;
        logic bl;
        presc = t % p;
        slot  = t / p;
        s     = slot % nd;
        frame = slot / nd;
        ph    = (frame / bf) % 2;
        bl    = bm[s] | (km[s] & (ph == 1));
        r.sel = 3'(s);
        r.de  = (e && presc >= dd && !bl) ? 8'(1 << s) : 8'h00;
        r.q   = bl ? 4'hF : din[s*4 +: 4];
        r.fs  = e && (t % (p * nd) == 0);
        return r;
    endfunction

    initial begin
        t0 = 0;
        t1 = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                t0 = 0;
                t1 = 0;
                sb0.delete();
                sb1.delete();
            end else begin
                if (en) begin
                    t0++;
                    t1++;
                end
                sb0.push_back(calc(t0, 4, 4, 1, 2, en, {16'h0, din0}, {4'h0, blank0}, {4'h0, blink0}));
                sb1.push_back(calc(t1, 5, 3, 0, 1, en, {12'h0, din1}, {3'h0, blank1}, {3'h0, blink1}));
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sb0.size() > 0) begin
                e = sb0.pop_front();
                check("u0_sel", {30'h0, sel0}, {29'h0, e.sel});
                check("u0_dig_en", {28'h0, de0}, {24'h0, e.de});
                check("u0_q", {28'h0, q0}, {28'h0, e.q});
                check("u0_frame_start", {31'h0, fs0}, {31'h0, e.fs});
                check("u0_onehot", {31'h0, $onehot0(de0)}, 32'h1);
            end
            if (!rst && sb1.size() > 0) begin
                e = sb1.pop_front();
                check("u1_sel", {29'h0, sel1}, {29'h0, e.sel});
                check("u1_dig_en", {27'h0, de1}, {24'h0, e.de});
                check("u1_q", {28'h0, q1}, {28'h0, e.q});
                check("u1_frame_start", {31'h0, fs1}, {31'h0, e.fs});
                check("u1_sel_range", {31'h0, (sel1 <= 3'd4)}, 32'h1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel0"}, {30'h0, sel0}, 32'h0);
        check({tag, "_de0"}, {28'h0, de0}, 32'h0);
        check({tag, "_q0"}, {28'h0, q0}, 32'h0);
        check({tag, "_fs0"}, {31'h0, fs0}, 32'h0);
        check({tag, "_sel1"}, {29'h0, sel1}, 32'h0);
        check({tag, "_de1"}, {27'h0, de1}, 32'h0);
        check({tag, "_q1"}, {28'h0, q1}, 32'h0);
    endtask

    initial begin
        bit found;
        rst    = 1'b1;
        en     = 1'b0;
        din0   = 16'h4321;
        din1   = 20'h76543;
        blank0 = '0;
        blink0 = '0;
        blank1 = '0;
        blink1 = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        rst = 1'b0;
        en  = 1'b1;
        repeat (8) @(negedge clk);

        // Blink on digit 2 (u0) and digit 1 (u1) across several frames.
        blink0 = 4'b0100;
        blink1 = 5'b00010;
        repeat (72) @(negedge clk);
        blink0 = '0;
        blink1 = '0;

        // Blank digit 0 one cycle into its slot, then remove it.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (fs0) found = 1;
        end
        check("wait_frame_start", {31'h0, found}, 32'h1);
        @(negedge clk);
        blank0 = 4'b0001;
        @(negedge clk);
        check("blank_dig_en", {28'h0, de0}, 32'h0);
        check("blank_q", {28'h0, q0}, 32'hF);
        blank0 = '0;
        @(negedge clk);
        check("unblank_dig_en", {28'h0, de0}, 32'h1);
        check("unblank_q", {28'h0, q0}, 32'h1);

        // Drop en for 10 cycles in the middle of the sel=2 slot.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (sel0 == 2'd2 && de0 == 4'b0000) found = 1;
        end
        check("wait_sel2", {31'h0, found}, 32'h1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_off_dig_en", {28'h0, de0}, 32'h0);
        check("en_off_sel", {30'h0, sel0}, 32'h2);
        repeat (9) @(negedge clk);
        check("en_hold_sel", {30'h0, sel0}, 32'h2);
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("resume_sel_still2", {30'h0, sel0}, 32'h2);
        check("resume_dig_en", {28'h0, de0}, 32'h4);
        @(negedge clk);
        check("resume_step_sel3", {30'h0, sel0}, 32'h3);
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
Parametrised time-multiplexed digit scanner for the seven-segment display path of the digital clock. It replaces a purely combinational select-driven mux with self-timed scanning: an internal prescaler steps the digit select, and the block produces a one-hot digit enable, the selected digit code, per-digit blank and blink masking, anti-ghosting dead time and a frame-start pulse. It sits between the timekeeping counters (packed BCD digits in) and the segment decoder / anode drivers (out).

Parameters:
DIGITS, 8, number of scanned digits (>=2)
DW, 4, bits per digit code
PRESCALE, 50000, clock cycles each digit is selected (>=2)
DEAD, 2, leading cycles of each digit slot with all enables off (0 <= DEAD < PRESCALE)
BLINK_FRAMES, 64, complete scan frames per blink half-period (>=1)
BLANK_CODE, 4'hF, value driven on q while the active digit is blanked (DW bits)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  scan enable; 0 freezes scanning and turns the display off
din  input  DIGITS*DW  packed digit codes; digit i = din[i*DW +: DW]
blank_mask  input  DIGITS  1 = digit i permanently off
blink_mask  input  DIGITS  1 = digit i off during blink phase 1
sel  output  SELW=max(1,clog2(DIGITS))  current digit index
dig_en  output  DIGITS  one-hot active-high digit enable, bit i = digit i
q  output  DW  code of the current digit
frame_start  output  1  one-cycle pulse when sel wraps to 0

Behaviour:
- Reset (async): prescaler=0, sel=0, dead_cnt=DEAD, frame_cnt=0, blink_phase=0, dig_en=0, q=0, frame_start=0.
- Prescaler: when en=1, counts 0..PRESCALE-1 and then wraps to 0. A "step" is the edge at which prescaler==PRESCALE-1 and en=1. When en=0, prescaler, sel, dead_cnt, frame_cnt and blink_phase all hold.
- Step: sel <= (sel==DIGITS-1) ? 0 : sel+1; dead_cnt <= DEAD.
- Between steps, dead_cnt decrements to 0 and saturates there (only while en=1).
- Wrap step (sel DIGITS-1 -> 0): frame_start=1 for exactly the following cycle. Also, if frame_cnt==BLINK_FRAMES-1 then frame_cnt<=0 and blink_phase toggles; otherwise frame_cnt increments. frame_start is not asserted after reset.
- Outputs are registered and computed from the next-state values (sel_n, dead_n), so they align cycle-for-cycle with sel:
  - blanked = blank_mask[sel_n] | (blink_mask[sel_n] & blink_phase_n).
  - dig_en <= (en && dead_n==0 && !blanked) ? onehot(sel_n) : 0.
  - q <= blanked ? BLANK_CODE : din[sel_n].
  - Latency from a din or mask change to q/dig_en: 1 cycle.
- Per digit slot: dig_en=0 for exactly DEAD cycles after each step, then one-hot for PRESCALE-DEAD cycles. With DEAD=0 there is no gap.
- en deassert: dig_en=0 from the next edge. q keeps tracking din[sel]. On re-assert, scanning resumes from the held prescaler, sel and dead_cnt values, with no extra dead time.
- dig_en never has more than one bit set.
- DIGITS not a power of two: sel never exceeds DIGITS-1.
- Reset mid-slot: all state returns to reset values immediately; the first slot after reset starts at sel=0 with the full DEAD gap.

Test Plan:
(Bench parameters: DIGITS=4, DW=4, PRESCALE=4, DEAD=1, BLINK_FRAMES=2, BLANK_CODE=F, unless noted.)
1. Reset then en=1, din=16'h4321, no masks -> sel sequence 0,1,2,3,0 with 4 cycles per value; in each slot dig_en is 0000 for 1 cycle, then 0001/0010/0100/1000 for 3 cycles; q = 1,2,3,4.
2. Run past the wrap -> frame_start high for exactly 1 cycle, coincident with the first sel=0 cycle of each frame; never high immediately after reset.
3. blink_mask=0100 -> digit 2 is shown in frames 0-1, shows dig_en=0 and q=F in frames 2-3, and is shown again in frame 4; the other digits are unaffected.
4. blank_mask=0001 mid-slot while sel=0 -> dig_en=0 and q=F on the next cycle; removing the mask restores dig_en=0001 and q=1 one cycle later.
5. Drop en for 10 cycles mid-slot at sel=2 -> dig_en=0 next cycle, sel stays 2; after re-assert the slot finishes its remaining prescaler count, then sel steps to 3.
6. DIGITS=5, DEAD=0 -> sel wraps 4 -> 0, never takes values 5-7; dig_en is never 0 while en=1 and no masks are set.
7. Assert rst asynchronously mid-scan -> all outputs are 0 immediately, without waiting for a clock edge.
